// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory-port arbiter: memory request/response
// payloads, arbiter state encoding, port indices and error-bit positions.
package mem_arbiter_pkg;

    typedef enum logic {
        MODE_READ  = 1'b0,
        MODE_WRITE = 1'b1
    } mem_mode_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        mem_mode_t   mode;
    } memreq;

    typedef struct packed {
        logic [31:0] data;
    } memresp;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam int N_ERR        = 3;
    localparam int ERR_OVERRUN  = 0;
    localparam int ERR_SPURIOUS = 1;
    localparam int ERR_TIMEOUT  = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory arbiter.
// MEM_ARB_RR_EN selects round-robin; otherwise the data port has fixed priority.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] pending,
    input  logic       rr_last,
    output logic       any,
    output logic       winner
);

    assign any = |pending;

`ifdef MEM_ARB_RR_EN
    // On contention the port that did not win last time goes next.
    always_comb begin
        if (&pending) winner = ~rr_last;
        else          winner = pending[PORT_DATA];
    end
`else
    logic unused_rr_last;
    assign unused_rr_last = rr_last;
    assign winner = pending[PORT_DATA];
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch (port 0) and data (port 1) requesters,
// one buffered request per port, one downstream transaction at a time.
// Optional build macro MEM_ARB_RR_EN: round-robin instead of data-first priority.
//
// state | meaning
// IDLE  | no downstream transaction; grants the next pending port
// WAIT  | request issued, waiting for response_enable (watchdog running)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req0_enable,
    input  memreq            req0,
    output logic             resp0_enable,
    output memresp           resp0,
    input  logic             req1_enable,
    input  memreq            req1,
    output logic             resp1_enable,
    output memresp           resp1,
    output logic             request_enable,
    output memreq            request,
    input  logic             response_enable,
    input  memresp           response,
    output logic             owner,
    output logic             busy,
    output logic [N_ERR-1:0] err
);

    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [1:0]       pending;
    logic [1:0]       req_en;
    memreq            req_in [2];
    memreq            buf_q  [2];
    logic [CNT_W-1:0] wd_cnt;
    logic             rr_last;
    logic             any_pending;
    logic             winner;
    logic             grant;
    logic             complete;
    logic             spurious;
    logic             wd_tick;
    logic             wd_hit;
    logic [1:0]       clr;

    assign req_en    = {req1_enable, req0_enable};
    assign req_in[0] = req0;
    assign req_in[1] = req1;

    mem_arb_pick u_pick (
        .pending (pending),
        .rr_last (rr_last),
        .any     (any_pending),
        .winner  (winner)
    );

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (!rstn)      rr_last <= 1'b1;
        else if (grant) rr_last <= winner;
    end
`else
    assign rr_last = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_pending) state_next = WAIT;
            WAIT:    if (response_enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-cycle strobes that drive the registered outputs and bookkeeping.
    always_comb begin
        grant    = 1'b0;
        complete = 1'b0;
        spurious = 1'b0;
        wd_tick  = 1'b0;
        wd_hit   = 1'b0;
        clr      = 2'b00;
        case (state)
            IDLE: begin
                grant    = any_pending;
                spurious = response_enable;
            end
            WAIT: begin
                complete   = response_enable;
                clr[owner] = response_enable;
                wd_tick    = (TIMEOUT != 0) && !response_enable && (wd_cnt != TIMEOUT_C);
                wd_hit     = wd_tick && (wd_cnt == TIMEOUT_M1);
            end
            default: spurious = response_enable;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pending        <= 2'b00;
            buf_q[0]       <= '0;
            buf_q[1]       <= '0;
            request_enable <= 1'b0;
            request        <= '0;
            owner          <= 1'b0;
            busy           <= 1'b0;
            resp0_enable   <= 1'b0;
            resp0          <= '0;
            resp1_enable   <= 1'b0;
            resp1          <= '0;
            err            <= '0;
        end else begin
            request_enable <= grant;
            resp0_enable   <= clr[PORT_FETCH];
            resp1_enable   <= clr[PORT_DATA];

            if (grant) begin
                request <= buf_q[winner];
                owner   <= winner;
                busy    <= 1'b1;
            end else if (complete) begin
                busy    <= 1'b0;
            end

            if (clr[PORT_FETCH]) resp0 <= response;
            if (clr[PORT_DATA])  resp1 <= response;

            // A slot freed on this edge can take a new request on the same edge.
            for (int i = 0; i < 2; i++) begin
                if (req_en[i] && (!pending[i] || clr[i])) begin
                    pending[i] <= 1'b1;
                    buf_q[i]   <= req_in[i];
                end else if (clr[i]) begin
                    pending[i] <= 1'b0;
                end
            end

            if (|(req_en & pending & ~clr)) err[ERR_OVERRUN]  <= 1'b1;
            if (spurious)                   err[ERR_SPURIOUS] <= 1'b1;
            if (wd_hit)                     err[ERR_TIMEOUT]  <= 1'b1;
        end
    end

    // Watchdog: cleared on grant, counts unanswered WAIT cycles, saturates.
    always_ff @(posedge clk) begin
        if (!rstn)        wd_cnt <= '0;
        else if (grant)   wd_cnt <= '0;
        else if (wd_tick) wd_cnt <= wd_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized phase checked against a cycle-level transaction model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       req0_enable, req1_enable, response_enable;
    memreq      req0, req1, request;
    memresp     resp0, resp1, response;
    logic       resp0_enable, resp1_enable, request_enable, owner, busy;
    logic [2:0] err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // random-phase model state
    bit         outst [2];
    bit         issued [2];
    int         acc [2];
    memreq      preq [2];
    bit         ds_busy, busy_nxt, v0, v1, e_req_en;
    int         ds_port, resp_cyc, last_grant, w, cnt_a, cnt_b;
    memreq      e_req;
    bit [1:0]   e_resp;
    logic [31:0] e_data;

    mem_arbiter #(.TIMEOUT(8), .CNT_W(16)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .req0_enable     (req0_enable),
        .req0            (req0),
        .resp0_enable    (resp0_enable),
        .resp0           (resp0),
        .req1_enable     (req1_enable),
        .req1            (req1),
        .resp1_enable    (resp1_enable),
        .resp1           (resp1),
        .request_enable  (request_enable),
        .request         (request),
        .response_enable (response_enable),
        .response        (response),
        .owner           (owner),
        .busy            (busy),
        .err             (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        req0_enable     = 1'b0;
        req1_enable     = 1'b0;
        response_enable = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    function automatic memreq mk(input logic [31:0] a, input logic wr);
        memreq r;
        r.addr  = a;
        r.wdata = a ^ 32'h5A5A_0000;
        r.wstrb = wr ? 4'h3 : 4'hF;
        r.mode  = wr ? MODE_WRITE : MODE_READ;
        return r;
    endfunction

    // Called in the cycle request_enable is expected; memory answers next cycle.
    task automatic xact(input int port, input logic [31:0] addr, input logic [31:0] data);
        chk("xact_req_en", request_enable, 1);
        chk("xact_owner", owner, port);
        chk("xact_addr", request.addr, addr);
        chk("xact_busy_wait", busy, 1);
        tick();
        response_enable = 1'b1;
        response.data   = data;
        chk("xact_req_pulse", request_enable, 0);
        tick();
        chk("xact_resp0_en", resp0_enable, port == 0);
        chk("xact_resp1_en", resp1_enable, port == 1);
        chk("xact_resp_data", (port == 0) ? resp0.data : resp1.data, data);
        chk("xact_busy_done", busy, 0);
    endtask

    initial begin
        rstn = 1'b0;
        req0_enable = 1'b0; req1_enable = 1'b0; response_enable = 1'b0;
        req0 = '0; req1 = '0; response = '0;

        // reset state
        do_reset();
        chk("rst_req_en", request_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_err", err, 0);
        chk("rst_resp_en", {resp1_enable, resp0_enable}, 0);
        chk("rst_request", request, 0);

        // single fetch: req at 0, issue at 2, response at 3, resp0 at 4
        req0_enable = 1'b1; req0 = mk(32'h100, 1'b0);
        tick();
        chk("fetch_c1_req_en", request_enable, 0);
        tick();
        chk("fetch_c2_req_en", request_enable, 1);
        chk("fetch_c2_addr", request.addr, 32'h100);
        chk("fetch_c2_owner", owner, 0);
        chk("fetch_c2_busy", busy, 1);
        tick();
        response_enable = 1'b1; response.data = 32'hDEADBEEF;
        chk("fetch_c3_resp1", resp1_enable, 0);
        tick();
        chk("fetch_c4_resp0_en", resp0_enable, 1);
        chk("fetch_c4_resp0", resp0.data, 32'hDEADBEEF);
        chk("fetch_c4_resp1", resp1_enable, 0);
        tick();
        chk("fetch_c5_resp0_pulse", resp0_enable, 0);

        // contention right after reset (rr_last=1)
        do_reset();
        req0_enable = 1'b1; req0 = mk(32'h10, 1'b0);
        req1_enable = 1'b1; req1 = mk(32'h20, 1'b1);
        tick();
        chk("cont_c1_req_en", request_enable, 0);
        tick();
        if (RR) xact(0, 32'h10, 32'h1111_0000);
        else    xact(1, 32'h20, 32'h2222_0000);
        chk("cont_gap_req_en", request_enable, 0);
        tick();
        if (RR) xact(1, 32'h20, 32'h2222_0001);
        else    xact(0, 32'h10, 32'h1111_0001);

        // lone data grant, then contention
        req1_enable = 1'b1; req1 = mk(32'h30, 1'b0);
        tick(); tick();
        xact(1, 32'h30, 32'h3333_0000);
        req0_enable = 1'b1; req0 = mk(32'h40, 1'b0);
        req1_enable = 1'b1; req1 = mk(32'h50, 1'b0);
        tick(); tick();
        if (RR) xact(0, 32'h40, 32'h4444_0000);
        else    xact(1, 32'h50, 32'h5555_0000);
        tick();
        if (RR) xact(1, 32'h50, 32'h5555_0001);
        else    xact(0, 32'h40, 32'h4444_0001);
        chk("cont_err", err, 0);

        // overrun: second data request dropped
        do_reset();
        req1_enable = 1'b1; req1 = mk(32'hA0, 1'b0);
        tick();
        req1_enable = 1'b1; req1 = mk(32'hB0, 1'b0);
        tick();
        chk("ovr_err0", err, 3'b001);
        xact(1, 32'hA0, 32'hAAAA_0000);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            cnt_a += int'(resp1_enable);
            cnt_b += int'(request_enable);
        end
        chk("ovr_extra_resp1", cnt_a, 0);
        chk("ovr_extra_issue", cnt_b, 0);
        chk("ovr_err_final", err, 3'b001);

        // spurious response while idle
        do_reset();
        response_enable = 1'b1; response.data = 32'hBAD0_0000;
        tick();
        chk("spur_err", err, 3'b010);
        chk("spur_resp_en", {resp1_enable, resp0_enable}, 0);
        chk("spur_busy", busy, 0);
        req0_enable = 1'b1; req0 = mk(32'h60, 1'b0);
        tick();
        chk("spur_c1_req_en", request_enable, 0);
        tick();
        xact(0, 32'h60, 32'h6666_0000);

        // watchdog: WAIT entered at c2, err[2] at c10, late response at c20
        do_reset();
        req0_enable = 1'b1; req0 = mk(32'h70, 1'b0);
        tick(); tick();
        chk("wd_c2_req_en", request_enable, 1);
        for (int c = 3; c <= 20; c++) begin
            tick();
            if (c == 9)  chk("wd_c9_err2", err[2], 0);
            if (c == 10) chk("wd_c10_err2", err[2], 1);
            if (c == 19) chk("wd_c19_busy", busy, 1);
            if (c == 20) begin
                response_enable = 1'b1;
                response.data   = 32'h7777_0000;
            end
        end
        tick();
        chk("wd_c21_resp0_en", resp0_enable, 1);
        chk("wd_c21_resp0", resp0.data, 32'h7777_0000);
        chk("wd_c21_err", err, 3'b100);

        // reset in the middle of WAIT
        do_reset();
        req1_enable = 1'b1; req1 = mk(32'h80, 1'b0);
        tick(); tick();
        chk("rmw_c2_busy", busy, 1);
        tick();
        do_reset();
        chk("rmw_busy", busy, 0);
        chk("rmw_err", err, 0);
        chk("rmw_req_en", request_enable, 0);
        cnt_b = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            cnt_b += int'(request_enable);
        end
        chk("rmw_no_reissue", cnt_b, 0);
        response_enable = 1'b1; response.data = 32'h8888_0000;
        tick();
        chk("rmw_late_err", err, 3'b010);
        chk("rmw_late_resp", {resp1_enable, resp0_enable}, 0);

        // randomized traffic against the model
        do_reset();
        outst = '{0, 0}; issued = '{0, 0}; acc = '{0, 0};
        ds_busy = 0; ds_port = 0; resp_cyc = 0; last_grant = 1;
        e_req_en = 0; e_req = '0; e_resp = 2'b00; e_data = '0;
        for (int c = 0; c < 600; c++) begin
            chk("rnd_req_en", request_enable, e_req_en);
            if (e_req_en) begin
                chk("rnd_owner", owner, w);
                chk("rnd_request", request, e_req);
            end
            chk("rnd_resp0_en", resp0_enable, e_resp[0]);
            chk("rnd_resp1_en", resp1_enable, e_resp[1]);
            if (e_resp[0]) chk("rnd_resp0", resp0.data, e_data);
            if (e_resp[1]) chk("rnd_resp1", resp1.data, e_data);
            chk("rnd_busy", busy, ds_busy);

            e_req_en = 0;
            e_resp   = 2'b00;
            busy_nxt = ds_busy;
            if (!ds_busy) begin
                v0 = outst[0] && !issued[0] && acc[0] < c;
                v1 = outst[1] && !issued[1] && acc[1] < c;
                if (v0 || v1) begin
                    if (v0 && v1) w = RR ? 1 - last_grant : 1;
                    else          w = v1 ? 1 : 0;
                    e_req_en   = 1;
                    e_req      = preq[w];
                    issued[w]  = 1;
                    ds_port    = w;
                    last_grant = w;
                    resp_cyc   = c + 1 + int'($urandom_range(0, 3));
                    busy_nxt   = 1;
                end
            end else if (c == resp_cyc) begin
                response_enable = 1'b1;
                response.data   = $urandom;
                e_data          = response.data;
                e_resp[ds_port] = 1'b1;
                outst[ds_port]  = 0;
                busy_nxt        = 0;
            end
            if (!outst[0] && $urandom_range(0, 2) == 0) begin
                req0_enable = 1'b1;
                req0 = mk($urandom, 1'($urandom_range(0, 1)));
                preq[0] = req0; outst[0] = 1; issued[0] = 0; acc[0] = c;
            end
            if (!outst[1] && $urandom_range(0, 2) == 0) begin
                req1_enable = 1'b1;
                req1 = mk($urandom, 1'($urandom_range(0, 1)));
                preq[1] = req1; outst[1] = 1; issued[1] = 0; acc[1] = c;
            end
            ds_busy = busy_nxt;
            tick();
        end
        chk("rnd_err", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
